rs_mul: RTL

RS_MUL -- requirements
Module: rs_mul

---
 rtl/sys_defs_pkg.sv | 39 +++
 rtl/rs_mul_psel.sv | 14 +
 rtl/rs_mul.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sys_defs_pkg.sv
// Shared machine-wide widths, ALU function codes and MUL reservation-station payloads.
package sys_defs_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned PRF_LEN     = 6;
  localparam int unsigned ROB_LEN     = 5;
  localparam int unsigned RS_MUL_SIZE = 4;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_MUL    = 3'd1,
    ALU_MULH   = 3'd2,
    ALU_MULHSU = 3'd3,
    ALU_MULHU  = 3'd4
  } alu_func_e;

  // Dispatch-side payload, also the per-entry storage format.
  typedef struct packed {
    logic [XLEN-1:0]    opa_value;
    logic [XLEN-1:0]    opb_value;
    logic               opa_ready;
    logic               opb_ready;
    logic [PRF_LEN-1:0] opa_preg_idx;
    logic [PRF_LEN-1:0] opb_preg_idx;
    logic [PRF_LEN-1:0] dest_preg_idx;
    logic [ROB_LEN-1:0] rob_idx;
    alu_func_e          alu_func;
  } rs_mul_dispatch_t;

  // Issue-side payload handed to the multiplier.
  typedef struct packed {
    logic [XLEN-1:0]    opa_value;
    logic [XLEN-1:0]    opb_value;
    logic [PRF_LEN-1:0] dest_preg_idx;
    logic [ROB_LEN-1:0] rob_idx;
    alu_func_e          alu_func;
  } rs_mul_packet_t;

endpackage

// File: rtl/rs_mul_psel.sv
// Lowest-index priority select: one-hot grant of the least significant set request bit.
module rs_mul_psel #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         found_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt_o   = req_i & (~req_i + N'(1));
  assign found_o = |req_i;

endmodule

// File: rtl/rs_mul.sv
// MUL reservation station: in-order-free allocation, CDB wakeup/forwarding, lowest-index issue.
module rs_mul
  import sys_defs_pkg::*;
#(
  parameter int unsigned N_ENTRIES = RS_MUL_SIZE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               squash,
  input  logic               dispatch_enable,
  input  rs_mul_dispatch_t   dispatch_packet,
  input  logic               cdb_valid,
  input  logic [PRF_LEN-1:0] cdb_preg_idx,
  input  logic [XLEN-1:0]    cdb_value,
  input  logic               mul_ready,
  output logic               rs_mul_full,
  output logic               mul_enable,
  output rs_mul_packet_t     rs_mul_packet
);

  logic [N_ENTRIES-1:0] valid_q, valid_d;
  rs_mul_dispatch_t     entry_q [N_ENTRIES];
  rs_mul_dispatch_t     entry_d [N_ENTRIES];
  logic                 mul_enable_q, mul_enable_d;
  rs_mul_packet_t       packet_q, packet_d;

  logic [N_ENTRIES-1:0] eligible;
  logic [N_ENTRIES-1:0] alloc_gnt, issue_gnt;
  logic                 has_free, any_eligible;
  logic                 dispatch_ok, do_issue;
  rs_mul_dispatch_t     disp_fwd;

  assign rs_mul_full   = &valid_q;
  assign mul_enable    = mul_enable_q;
  assign rs_mul_packet = packet_q;

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      eligible[i] = valid_q[i] & entry_q[i].opa_ready & entry_q[i].opb_ready;
    end
  end

  rs_mul_psel #(.N(N_ENTRIES)) u_free_sel (
    .req_i   (~valid_q),
    .gnt_o   (alloc_gnt),
    .found_o (has_free)
  );

  rs_mul_psel #(.N(N_ENTRIES)) u_issue_sel (
    .req_i   (eligible),
    .gnt_o   (issue_gnt),
    .found_o (any_eligible)
  );

  assign dispatch_ok = dispatch_enable & has_free;
  assign do_issue    = mul_ready & any_eligible;

  // Same-cycle CDB forwarding into the incoming instruction.
  always_comb begin
    disp_fwd = dispatch_packet;
    if (cdb_valid && !dispatch_packet.opa_ready &&
        dispatch_packet.opa_preg_idx == cdb_preg_idx) begin
      disp_fwd.opa_ready = 1'b1;
      disp_fwd.opa_value = cdb_value;
    end
    if (cdb_valid && !dispatch_packet.opb_ready &&
        dispatch_packet.opb_preg_idx == cdb_preg_idx) begin
      disp_fwd.opb_ready = 1'b1;
      disp_fwd.opb_value = cdb_value;
    end
  end

  always_comb begin
    valid_d      = valid_q;
    entry_d      = entry_q;
    mul_enable_d = do_issue & ~squash;
    packet_d     = packet_q;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (valid_q[i] && cdb_valid) begin
        if (!entry_q[i].opa_ready && entry_q[i].opa_preg_idx == cdb_preg_idx) begin
          entry_d[i].opa_ready = 1'b1;
          entry_d[i].opa_value = cdb_value;
        end
        if (!entry_q[i].opb_ready && entry_q[i].opb_preg_idx == cdb_preg_idx) begin
          entry_d[i].opb_ready = 1'b1;
          entry_d[i].opb_value = cdb_value;
        end
      end
      if (do_issue && issue_gnt[i]) begin
        valid_d[i] = 1'b0;
        if (!squash) begin
          packet_d.opa_value     = entry_q[i].opa_value;
          packet_d.opb_value     = entry_q[i].opb_value;
          packet_d.dest_preg_idx = entry_q[i].dest_preg_idx;
          packet_d.rob_idx       = entry_q[i].rob_idx;
          packet_d.alu_func      = entry_q[i].alu_func;
        end
      end
      // Free slots come from current state, so a slot issued this cycle is not reused yet.
      if (dispatch_ok && alloc_gnt[i]) begin
        valid_d[i] = 1'b1;
        entry_d[i] = disp_fwd;
      end
    end
    if (squash) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      mul_enable_q <= 1'b0;
      packet_q     <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      mul_enable_q <= mul_enable_d;
      packet_q     <= packet_d;
      for (int i = 0; i < N_ENTRIES; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

endmodule
